producer2riscv: RTL

Inbound stream adapter between an upstream producer's valid/ready port (din/val_in/ready_upward) and one CPU input channel of the picorv memory-map block. It is the receive-side counterpart of riscv2consumer. It buffers up to DEPTH words in a first-word-fall-through FIFO, so the CPU can pop words at its own pace without back-pressure glitches reaching the producer. One instance is used per input channel (1..5).

---
 rtl/producer2riscv_pkg.sv | 14 +
 rtl/producer2riscv_ram.sv | 32 +++
 rtl/producer2riscv.sv | 101 ++++++++++
 3 files changed

// File: rtl/producer2riscv_pkg.sv
// Shared stream parameters for the picorv stream adapters.
//   STREAM_DW       : stream word width used by every channel
//   CHAN_FIFO_DEPTH : default per-channel FIFO depth (power of 2, >= 2)
package producer2riscv_pkg;

    localparam int unsigned STREAM_DW       = 32;
    localparam int unsigned CHAN_FIFO_DEPTH = 4;

    // True when d is a power of two and at least 2; usable in elaboration checks.
    function automatic bit depth_ok(input int unsigned d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/producer2riscv_ram.sv
// Simple dual-port register array for the producer2riscv FIFO.
//   clk     : write clock
//   wr_en   : write strobe (one word per edge)
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : asynchronous read address
//   rd_data : asynchronous read data
// Contents are deliberately not reset.
module producer2riscv_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/producer2riscv.sv
// Inbound stream adapter: producer valid/ready port -> CPU input channel.
// First-word-fall-through FIFO of DEPTH words with a registered head word.
//   clk            : clock, rising edge
//   resetn         : asynchronous active-low reset
//   din            : word from the producer
//   val_in         : din valid
//   ready_upward   : FIFO can accept a word (not full)
//   dout           : head-of-FIFO word (last popped word, or 0, when empty)
//   val_out        : dout holds an unread word
//   ready_downward : CPU pops the head word this cycle
//   count          : occupancy, 0..DEPTH
module producer2riscv
    import producer2riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = STREAM_DW,
    parameter int unsigned DEPTH      = CHAN_FIFO_DEPTH,
    localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  val_in,
    output logic                  ready_upward,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  val_out,
    input  logic                  ready_downward,
    output logic [ADDR_W:0]       count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       count_q,  count_d;
    logic [DATA_WIDTH-1:0] dout_q,   dout_d;
    logic [DATA_WIDTH-1:0] ram_rd;
    logic                  push, pop;
    logic                  head_from_din;

    // Handshake decodes come only from registered count, so neither ready
    // depends combinationally on the opposite side.
    assign ready_upward = (count_q != FULL_CNT);
    assign val_out      = (count_q != '0);
    assign push         = val_in && ready_upward;
    assign pop          = val_out && ready_downward;

    assign dout  = dout_q;
    assign count = count_q;

    // The RAM is read at the post-pop pointer so the head register can be
    // loaded with the word that becomes oldest after this edge.
    producer2riscv_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (din),
        .rd_addr (rd_ptr_d),
        .rd_data (ram_rd)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d = rd_ptr_q + ADDR_W'(pop);

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // The incoming word becomes the head when nothing older survives this
        // edge; it is not yet in the RAM, so bypass din.
        head_from_din = push && ((count_q == '0) || ((count_q == 1) && pop));

        dout_d = dout_q;
        if (head_from_din) begin
            dout_d = din;
        end else if (count_d != '0) begin
            dout_d = ram_rd;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

endmodule
